// File: rtl/vga_pixel_feeder_pkg.sv
// Shared VGA timing constants, feeder FSM states and the pixel record stored in the FIFO.
// The sync stage imports the same constants so both sides agree on the frame geometry.
package vga_pixel_feeder_pkg;

    localparam int PIX_DATA_W = 8;

    // 800x600 @ 60 Hz SVGA timing
    localparam int H_ACT   = 800;
    localparam int H_FP    = 40;
    localparam int H_SYNC  = 128;
    localparam int H_BP    = 88;
    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_ACT   = 600;
    localparam int V_FP    = 1;
    localparam int V_SYNC  = 4;
    localparam int V_BP    = 23;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        ALIGN  = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } feed_state_e;

    typedef struct packed {
        logic                  sof;
        logic [PIX_DATA_W-1:0] r;
        logic [PIX_DATA_W-1:0] g;
        logic [PIX_DATA_W-1:0] b;
    } pixel_t;

    // The pixel counter only ever holds 0..n-1, so clog2(n) bits suffice
    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_pixel_feeder_if.sv
// Stream-side, display-side and status signals of the pixel feeder in one bundle.
// slave is the feeder's view, master is the view of whatever drives it.
interface vga_pixel_feeder_if
    import vga_pixel_feeder_pkg::*;
#(
    parameter int DATA_W = PIX_DATA_W
);

    logic              s_valid;
    logic              s_ready;
    logic              s_sof;
    logic [DATA_W-1:0] s_r;
    logic [DATA_W-1:0] s_g;
    logic [DATA_W-1:0] s_b;

    logic              disp_req;
    logic              disp_sof;
    logic [DATA_W-1:0] pix_r;
    logic [DATA_W-1:0] pix_g;
    logic [DATA_W-1:0] pix_b;
    logic              pix_fill;

    logic              underflow;
    logic              sync_err;
    logic              clr_status;

    modport slave (
        input  s_valid, s_sof, s_r, s_g, s_b, disp_req, disp_sof, clr_status,
        output s_ready, pix_r, pix_g, pix_b, pix_fill, underflow, sync_err
    );

    modport master (
        output s_valid, s_sof, s_r, s_g, s_b, disp_req, disp_sof, clr_status,
        input  s_ready, pix_r, pix_g, pix_b, pix_fill, underflow, sync_err
    );

endinterface

// File: rtl/vga_pixel_feeder_fifo.sv
// Register-array FIFO with extra-bit pointers; the head entry is read straight from the
// storage registers, so a word written this cycle becomes visible at the head next cycle.
module pixel_fifo #(
    parameter int WIDTH  = 25,
    parameter int ADDR_W = 4
) (
    input  logic             clock,
    input  logic             areset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W:0]   wrPtr_q;
    logic [ADDR_W:0]   rdPtr_q;
    logic              doPush;
    logic              doPop;

    // Pointers differ only in the MSB when the write side has lapped the read side
    assign full_o  = (wrPtr_q[ADDR_W] != rdPtr_q[ADDR_W]) &&
                     (wrPtr_q[ADDR_W-1:0] == rdPtr_q[ADDR_W-1:0]);
    assign empty_o = (wrPtr_q == rdPtr_q);

    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    assign data_o = mem_q[rdPtr_q[ADDR_W-1:0]];

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + (ADDR_W+1)'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[wrPtr_q[ADDR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/vga_pixel_feeder.sv
// Elastic buffer from the upstream pixel stream to the VGA output stage: aligns stream frames
// to display frames and substitutes a fill colour whenever no correctly aligned pixel exists.
module vga_pixel_feeder
    import vga_pixel_feeder_pkg::*;
#(
    parameter int               DATA_W   = PIX_DATA_W,
    parameter int               ADDR_W   = 4,
    parameter int               H_ACT    = vga_pixel_feeder_pkg::H_ACT,
    parameter int               V_ACT    = vga_pixel_feeder_pkg::V_ACT,
    parameter logic [3*DATA_W-1:0] FILL_RGB = '0
) (
    input  logic              clock,
    input  logic              areset,
    vga_pixel_feeder_if.slave bus
);

    localparam int FRAME_PIX = H_ACT * V_ACT;
    localparam int CNT_W     = cntWidth(FRAME_PIX);
    localparam int RGB_W     = 3 * DATA_W;

    feed_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RGB_W-1:0]   pixRgb_q;
    logic               pixFill_q;
    logic               underflow_q;
    logic               syncErr_q;

    logic [RGB_W:0]     fifoIn;
    logic [RGB_W:0]     head;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               pop;
    logic               takeHead;
    logic               setUnderflow;
    logic               setSyncErr;
    logic               headSof;
    logic [RGB_W-1:0]   headRgb;

    assign fifoIn  = {bus.s_sof, bus.s_r, bus.s_g, bus.s_b};
    assign headSof = head[RGB_W];
    assign headRgb = head[RGB_W-1:0];

    // Held low for the whole reset, independent of the clock
    assign bus.s_ready = !fifoFull && !areset;

    pixel_fifo #(
        .WIDTH  (RGB_W + 1),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clock   (clock),
        .areset  (areset),
        .push_i  (bus.s_valid && bus.s_ready),
        .data_i  (fifoIn),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pop          = 1'b0;
        takeHead     = 1'b0;
        setUnderflow = 1'b0;
        setSyncErr   = 1'b0;
        case (state_q)
            ALIGN: begin
                if (!fifoEmpty) begin
                    if (headSof) begin
                        state_d = WAIT;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (bus.disp_req && bus.disp_sof && !fifoEmpty && headSof) begin
                    pop      = 1'b1;
                    takeHead = 1'b1;
                    cnt_d    = CNT_W'(1);
                    state_d  = (FRAME_PIX == 1) ? WAIT : STREAM;
                end else if (!fifoEmpty && !headSof) begin
                    // A frame-complete exit can leave mid-frame data at the head; go discard it
                    state_d = ALIGN;
                end
            end
            STREAM: begin
                if (bus.disp_req) begin
                    if (fifoEmpty) begin
                        setUnderflow = 1'b1;
                        cnt_d        = '0;
                        state_d      = ALIGN;
                    end else if (headSof) begin
                        setSyncErr = 1'b1;
                        cnt_d      = '0;
                        state_d    = WAIT;
                    end else if (bus.disp_sof) begin
                        setSyncErr = 1'b1;
                        cnt_d      = '0;
                        state_d    = ALIGN;
                    end else begin
                        pop      = 1'b1;
                        takeHead = 1'b1;
                        if (cnt_q == CNT_W'(FRAME_PIX - 1)) begin
                            cnt_d   = '0;
                            state_d = WAIT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ALIGN;
            end
        endcase
    end

    // Output pixel only moves on a display request; a status clear beats a same-cycle set
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state_q     <= ALIGN;
            cnt_q       <= '0;
            pixRgb_q    <= '0;
            pixFill_q   <= 1'b1;
            underflow_q <= 1'b0;
            syncErr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (bus.disp_req) begin
                pixRgb_q  <= takeHead ? headRgb : FILL_RGB;
                pixFill_q <= !takeHead;
            end
            if (bus.clr_status) begin
                underflow_q <= 1'b0;
                syncErr_q   <= 1'b0;
            end else begin
                underflow_q <= underflow_q || setUnderflow;
                syncErr_q   <= syncErr_q || setSyncErr;
            end
        end
    end

    assign bus.pix_r     = pixRgb_q[3*DATA_W-1 -: DATA_W];
    assign bus.pix_g     = pixRgb_q[2*DATA_W-1 -: DATA_W];
    assign bus.pix_b     = pixRgb_q[DATA_W-1 -: DATA_W];
    assign bus.pix_fill  = pixFill_q;
    assign bus.underflow = underflow_q;
    assign bus.sync_err  = syncErr_q;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for the pixel feeder on a 4x2 frame: alignment, underflow, backpressure,
// early stream SOF and asynchronous reset.
module tb_vga_pixel_feeder;
    import vga_pixel_feeder_pkg::*;

    localparam logic [31:0] FILL_EXP = 32'h0100_0000;

    logic clock;
    logic areset;
    int   totalChecks = 0;
    int   badChecks   = 0;

    vga_pixel_feeder_if #(.DATA_W(8)) bus ();

    vga_pixel_feeder #(
        .DATA_W   (8),
        .ADDR_W   (4),
        .H_ACT    (4),
        .V_ACT    (2),
        .FILL_RGB (24'h0)
    ) dut (
        .clock  (clock),
        .areset (areset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Pixel k carries R=k, G=k+0x10, B=k+0x20
    function automatic logic [31:0] expPix(input logic [7:0] k);
        logic [7:0] g;
        logic [7:0] b;
        g = k + 8'h10;
        b = k + 8'h20;
        return {7'd0, 1'b0, k, g, b};
    endfunction

    function automatic logic [31:0] pixOut();
        return {7'd0, bus.pix_fill, bus.pix_r, bus.pix_g, bus.pix_b};
    endfunction

    task automatic applyStimulus(input logic sv, input logic ssof, input logic [7:0] k,
                                 input logic req, input logic dsof, input logic clr);
        bus.s_valid    = sv;
        bus.s_sof      = ssof;
        bus.s_r        = k;
        bus.s_g        = k + 8'h10;
        bus.s_b        = k + 8'h20;
        bus.disp_req   = req;
        bus.disp_sof   = dsof;
        bus.clr_status = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic pushPix(input logic [7:0] k, input logic sof);
        applyStimulus(1'b1, sof, k, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reqPix(input logic dsof);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, dsof, 1'b0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic pushFrame(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            pushPix(base + 8'(i), i == 0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        areset         = 1'b1;
        bus.s_valid    = 1'b0;
        bus.s_sof      = 1'b0;
        bus.s_r        = '0;
        bus.s_g        = '0;
        bus.s_b        = '0;
        bus.disp_req   = 1'b0;
        bus.disp_sof   = 1'b0;
        bus.clr_status = 1'b0;

        #3;
        checkOutput("rst_pix", pixOut(), FILL_EXP);
        checkOutput("rst_ready", 32'(bus.s_ready), 32'd0);
        checkOutput("rst_underflow", 32'(bus.underflow), 32'd0);
        checkOutput("rst_syncerr", 32'(bus.sync_err), 32'd0);
        repeat (2) @(posedge clock);
        #3 areset = 1'b0;
        idleCycles(1);
        checkOutput("post_rst_ready", 32'(bus.s_ready), 32'd1);
        checkOutput("post_rst_state", 32'(dut.state_q), 32'(ALIGN));

        // Aligned frame from a preloaded FIFO
        pushFrame(8'd1, 8);
        idleCycles(1);
        for (int i = 1; i <= 8; i++) begin
            reqPix(i == 1);
            checkOutput($sformatf("t1_pix%0d", i), pixOut(), expPix(8'(i)));
        end
        checkOutput("t1_state", 32'(dut.state_q), 32'(WAIT));
        checkOutput("t1_underflow", 32'(bus.underflow), 32'd0);
        checkOutput("t1_syncerr", 32'(bus.sync_err), 32'd0);

        // Garbage ahead of a frame is discarded
        for (int i = 0; i < 3; i++) begin
            pushPix(8'hE0 + 8'(i), 1'b0);
        end
        pushFrame(8'd1, 8);
        idleCycles(2);
        for (int i = 1; i <= 8; i++) begin
            reqPix(i == 1);
            checkOutput($sformatf("t2_pix%0d", i), pixOut(), expPix(8'(i)));
        end

        // Short frame runs dry
        pushFrame(8'd1, 5);
        idleCycles(1);
        for (int i = 1; i <= 8; i++) begin
            reqPix(i == 1);
            if (i <= 5) begin
                checkOutput($sformatf("t3_pix%0d", i), pixOut(), expPix(8'(i)));
            end else begin
                checkOutput($sformatf("t3_fill%0d", i), pixOut(), FILL_EXP);
            end
            if (i == 5) checkOutput("t3_uf_before", 32'(bus.underflow), 32'd0);
            if (i == 6) checkOutput("t3_uf_set", 32'(bus.underflow), 32'd1);
        end
        idleCycles(3);
        checkOutput("t3_uf_sticky", 32'(bus.underflow), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3_uf_clr", 32'(bus.underflow), 32'd0);

        // Backpressure at 16 entries
        pushFrame(8'd1, 16);
        checkOutput("t4_full_ready", 32'(bus.s_ready), 32'd0);
        pushPix(8'd17, 1'b0);
        checkOutput("t4_refused_ready", 32'(bus.s_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd17, 1'b1, 1'b1, 1'b0);
        checkOutput("t4_pop_pix", pixOut(), expPix(8'd1));
        checkOutput("t4_pop_ready", 32'(bus.s_ready), 32'd1);
        for (int i = 2; i <= 8; i++) begin
            reqPix(1'b0);
            checkOutput($sformatf("t4_pix%0d", i), pixOut(), expPix(8'(i)));
        end
        idleCycles(12);
        checkOutput("t4_drained", 32'(dut.u_fifo.empty_o), 32'd1);
        checkOutput("t4_state", 32'(dut.state_q), 32'(ALIGN));

        // Stream SOF arrives early, at request 6
        pushFrame(8'd1, 5);
        pushFrame(8'h41, 8);
        idleCycles(1);
        for (int i = 1; i <= 5; i++) begin
            reqPix(i == 1);
            checkOutput($sformatf("t5_pix%0d", i), pixOut(), expPix(8'(i)));
        end
        checkOutput("t5_se_before", 32'(bus.sync_err), 32'd0);
        reqPix(1'b0);
        checkOutput("t5_fill6", pixOut(), FILL_EXP);
        checkOutput("t5_se_set", 32'(bus.sync_err), 32'd1);
        for (int i = 0; i < 8; i++) begin
            reqPix(i == 0);
            checkOutput($sformatf("t5_b%0d", i), pixOut(), expPix(8'h41 + 8'(i)));
        end
        checkOutput("t5_se_sticky", 32'(bus.sync_err), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_se_clr", 32'(bus.sync_err), 32'd0);

        // Asynchronous reset in the middle of a frame
        pushFrame(8'd1, 8);
        idleCycles(1);
        for (int i = 1; i <= 3; i++) begin
            reqPix(i == 1);
        end
        checkOutput("t6_pix3", pixOut(), expPix(8'd3));
        bus.disp_req = 1'b0;
        bus.disp_sof = 1'b0;
        #2 areset = 1'b1;
        #1;
        checkOutput("t6_async_pix", pixOut(), FILL_EXP);
        checkOutput("t6_async_ready", 32'(bus.s_ready), 32'd0);
        @(posedge clock);
        #3 areset = 1'b0;
        idleCycles(1);
        checkOutput("t6_empty", 32'(dut.u_fifo.empty_o), 32'd1);
        checkOutput("t6_ready", 32'(bus.s_ready), 32'd1);
        checkOutput("t6_state", 32'(dut.state_q), 32'(ALIGN));
        reqPix(1'b1);
        checkOutput("t6_fill", pixOut(), FILL_EXP);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
